gat_aggregator: RTL and testbench
=================================

Name: gat_aggregator

Overview:
- Consumes one softmax result per destination node: an alpha vector, a node count and a pulse marking it valid.
- Reads the neighbour feature rows (WH) from the feature buffer and accumulates the alpha-weighted sum per output feature.
- Emits the aggregated feature vector over a valid/ready handshake.
- Sits directly downstream of softmax in the GAT layer pipeline and closes the attention path.

Parameters:
- MAX_NODES, 168, max neighbours per destination node (incl. self).
- NUM_NODE_WIDTH, $clog2(MAX_NODES)+1, node-count width.
- ALPHA_DATA_WIDTH, 32, unsigned alpha width.
- ALPHA_FRAC, 16, fractional bits of alpha.
- NUM_FEATURE_OUT, 16, features per WH row.
- WH_DATA_WIDTH, 16, signed WH element width.
- AGG_DATA_WIDTH, 32, signed output element width.
- WH_ADDR_W, 12, WH buffer row-address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- sm_ready_i  in  1  one-cycle pulse: alpha_i/sm_num_of_nodes_i valid this cycle
- alpha_i  in  MAX_NODES*ALPHA_DATA_WIDTH  alpha vector, index = neighbour order
- sm_num_of_nodes_i  in  NUM_NODE_WIDTH  neighbour count N
- wh_base_addr_i  in  WH_ADDR_W  row address of neighbour 0, sampled with sm_ready_i
- wh_rd_en_o  out  1  WH buffer read enable
- wh_rd_addr_o  out  WH_ADDR_W  WH row address
- wh_rd_data_i  in  NUM_FEATURE_OUT*WH_DATA_WIDTH  WH row, valid 1 cycle after wh_rd_en_o
- feat_valid_o  out  1  aggregated vector valid
- feat_ready_i  in  1  downstream accepts
- feat_o  out  NUM_FEATURE_OUT*AGG_DATA_WIDTH  aggregated vector
- agg_busy_o  out  1  job in RUN/DRAIN/OUT
- overflow_o  out  1  sticky: job dropped

Behaviour:
- Reset: all outputs 0; state IDLE; accumulators, job slots and read pipe cleared.
- Job slots:
  - active job plus one pending slot, each holding {alpha vector, N, base addr}.
  - sm_ready_i in IDLE: job loads into active.
  - sm_ready_i while busy: job goes to pending if pending is empty; otherwise it is dropped and overflow_o is set.
  - overflow_o is cleared only by reset.
- FSM: IDLE -> RUN -> DRAIN -> OUT -> (IDLE | RUN from pending).
- RUN:
  - issues wh_rd_en_o=1 on N consecutive cycles, addr = base+k, k=0..N-1; addr wraps modulo 2^WH_ADDR_W.
  - after the last issue -> DRAIN.
- Read-data tracking: a 1-cycle delayed valid/index pipe tags returning data.
  - on each tagged cycle: acc[f] += signed(wh[f]) * signed({1'b0, alpha[k]}), full precision.
  - accumulator width = WH_DATA_WIDTH+ALPHA_DATA_WIDTH+1+NUM_NODE_WIDTH.
- DRAIN: waits 1 cycle for the last data, then -> OUT.
- OUT output formation:
  - feat_o[f] = sat(acc[f] >>> ALPHA_FRAC), arithmetic shift (truncation toward -inf).
  - saturates to signed AGG_DATA_WIDTH range.
  - registered, held stable while feat_valid_o=1 and feat_ready_i=0.
- OUT handshake:
  - transfer on feat_valid_o & feat_ready_i; accumulators cleared on that cycle.
  - next state = RUN with pending promoted if pending is valid, else IDLE.
- Latency:
  - sm_ready_i sampled at edge E0 (IDLE) -> first wh_rd_en_o in cycle after E0.
  - feat_valid_o rises N+2 cycles after E0 (ready held high).
- N=0: no reads; RUN -> DRAIN immediately; feat_o=0, feat_valid_o at E0+2.
- N>MAX_NODES: clamped to MAX_NODES.
- sm_ready_i in the same cycle as an OUT transfer with pending empty: the job goes to pending, then promotes the same edge. Next cycle state=RUN with the new job; no job lost.
- Back-to-back sm_ready_i pulses with pending full: the first is accepted, later pulses are dropped and flagged.
- Reset mid-job: aborts immediately; no output vector; the pending slot is lost.

Decomposition:
- params_pkg gains:
  - AGG_DATA_WIDTH, ALPHA_FRAC, WH_ADDR_W, NUM_FEATURE_OUT;
  - agg_state_t enum {AGG_IDLE, AGG_RUN, AGG_DRAIN, AGG_OUT};
  - typedef agg_job_t packed struct {alpha vector, N, base}.
- One sub-module, gat_agg_mac: NUM_FEATURE_OUT parallel signed MAC lanes with clear/enable and output shift+saturate. The FSM, job slots and read pipe stay in the top module.

Test Plan:
- Basic weighted sum: N=2, alpha={0x8000,0x8000}, base=10, feat0 rows {100,-40} -> reads addr 10,11; feat_o[0]=30; feat_valid_o at E0+4.
- Saturation: AGG_DATA_WIDTH=16, N=2, alpha={0x10000,0x10000}, feat0 {30000,30000} -> feat_o[0]=32767; {-30000,-30000} -> -32768.
- Truncation: N=1, alpha=0x4000, feat0=-3 -> feat_o[0]=-1 (floor of -0.75). N=0 -> zero vector at E0+2, no wh_rd_en_o.
- Backpressure and pending: hold feat_ready_i=0 for 10 cycles, pulse sm_ready_i during RUN -> first vector stable throughout; second job starts the cycle after the transfer; third pulse while pending is full -> overflow_o=1 and only two vectors emitted.
- Wrap and reset: base=0xFFF, N=3 -> addrs 0xFFF, 0x000, 0x001. Assert rst_n low mid-RUN -> all outputs 0 immediately; next job after reset produces a correct result.

Source files
------------

// File: rtl/gat_aggregator_pkg.sv
// gat_aggregator_pkg: shared widths, FSM state codes and the job record for the
// GAT aggregation stage (alpha-weighted neighbour feature sum).
// No ports; imported by gat_aggregator_if, gat_agg_mac and gat_aggregator.
package gat_aggregator_pkg;

  localparam int MAX_NODES        = 168;
  localparam int NUM_NODE_WIDTH   = $clog2(MAX_NODES) + 1;
  localparam int NODE_IDX_W       = $clog2(MAX_NODES);
  localparam int ALPHA_DATA_WIDTH = 32;
  localparam int ALPHA_FRAC       = 16;
  localparam int NUM_FEATURE_OUT  = 16;
  localparam int WH_DATA_WIDTH    = 16;
  localparam int AGG_DATA_WIDTH   = 32;
  localparam int WH_ADDR_W        = 12;

  // Full-precision accumulator: signed WH x unsigned alpha (+1 sign bit),
  // plus headroom for summing up to MAX_NODES products.
  localparam int ACC_W = WH_DATA_WIDTH + ALPHA_DATA_WIDTH + 1 + NUM_NODE_WIDTH;

  typedef logic [1:0] agg_state_t;
  localparam logic [1:0] AGG_IDLE  = 2'd0;
  localparam logic [1:0] AGG_RUN   = 2'd1;
  localparam logic [1:0] AGG_DRAIN = 2'd2;
  localparam logic [1:0] AGG_OUT   = 2'd3;

  typedef struct packed {
    logic [MAX_NODES-1:0][ALPHA_DATA_WIDTH-1:0] alpha;
    logic [NUM_NODE_WIDTH-1:0]                  num;
    logic [WH_ADDR_W-1:0]                       base;
  } agg_job_t;

  // Neighbour counts above the alpha vector length are clamped to it.
  function automatic logic [NUM_NODE_WIDTH-1:0] clamp_nodes(
    input logic [NUM_NODE_WIDTH-1:0] n
  );
    if (n > NUM_NODE_WIDTH'(MAX_NODES)) return NUM_NODE_WIDTH'(MAX_NODES);
    return n;
  endfunction

  // A zero-neighbour job has nothing to issue and goes straight to DRAIN.
  function automatic agg_state_t start_state(input logic [NUM_NODE_WIDTH-1:0] n);
    return (n == '0) ? AGG_DRAIN : AGG_RUN;
  endfunction

endpackage

// File: rtl/gat_aggregator_if.sv
// gat_aggregator_if: bundles the softmax job input, the WH buffer read port and
// the aggregated-feature output handshake of gat_aggregator.
// Modports: slave = aggregator side, master = surrounding pipeline / memory side.
interface gat_aggregator_if;
  import gat_aggregator_pkg::*;

  // softmax job input
  logic                                       sm_ready_i;
  logic [MAX_NODES*ALPHA_DATA_WIDTH-1:0]      alpha_i;
  logic [NUM_NODE_WIDTH-1:0]                  sm_num_of_nodes_i;
  logic [WH_ADDR_W-1:0]                       wh_base_addr_i;
  // WH buffer read port (data returns one cycle after the enable)
  logic                                       wh_rd_en_o;
  logic [WH_ADDR_W-1:0]                       wh_rd_addr_o;
  logic [NUM_FEATURE_OUT*WH_DATA_WIDTH-1:0]   wh_rd_data_i;
  // aggregated feature output
  logic                                       feat_valid_o;
  logic                                       feat_ready_i;
  logic [NUM_FEATURE_OUT*AGG_DATA_WIDTH-1:0]  feat_o;
  // status
  logic                                       agg_busy_o;
  logic                                       overflow_o;

  modport slave (
    input  sm_ready_i, alpha_i, sm_num_of_nodes_i, wh_base_addr_i,
    input  wh_rd_data_i, feat_ready_i,
    output wh_rd_en_o, wh_rd_addr_o, feat_valid_o, feat_o, agg_busy_o, overflow_o
  );

  modport master (
    output sm_ready_i, alpha_i, sm_num_of_nodes_i, wh_base_addr_i,
    output wh_rd_data_i, feat_ready_i,
    input  wh_rd_en_o, wh_rd_addr_o, feat_valid_o, feat_o, agg_busy_o, overflow_o
  );

endinterface

// File: rtl/gat_aggregator_mac.sv
// Purpose: NUM_FEATURE_OUT parallel signed MAC lanes (WH x alpha) with shift+saturate view.
// Latency: product accumulates on the edge where en=1; feat is a combinational view of acc.
// Backpressure: none; clr has priority over en, the owner decides when to clear.
// Ports: clk, rst_n, clr (zero all lanes), en (accumulate this cycle),
//        wh_row (one WH row), alpha (unsigned Q.ALPHA_FRAC weight), feat (saturated lanes).
module gat_agg_mac
  import gat_aggregator_pkg::*;
(
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      clr,
  input  logic                                      en,
  input  logic [NUM_FEATURE_OUT*WH_DATA_WIDTH-1:0]  wh_row,
  input  logic [ALPHA_DATA_WIDTH-1:0]               alpha,
  output logic [NUM_FEATURE_OUT*AGG_DATA_WIDTH-1:0] feat
);

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-AGG_DATA_WIDTH+1){1'b0}}, {(AGG_DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-AGG_DATA_WIDTH+1){1'b1}}, {(AGG_DATA_WIDTH-1){1'b0}}};

  logic signed [ACC_W-1:0]          acc     [NUM_FEATURE_OUT];
  logic signed [ACC_W-1:0]          prod    [NUM_FEATURE_OUT];
  logic signed [ACC_W-1:0]          shifted [NUM_FEATURE_OUT];
  logic signed [ALPHA_DATA_WIDTH:0] alpha_s;

  // alpha is unsigned: a zero sign bit keeps the signed multiply exact.
  assign alpha_s = {1'b0, alpha};

  always_comb begin
    for (int f = 0; f < NUM_FEATURE_OUT; f++) begin
      prod[f] = ACC_W'($signed(wh_row[f*WH_DATA_WIDTH +: WH_DATA_WIDTH])) * ACC_W'(alpha_s);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < NUM_FEATURE_OUT; f++) acc[f] <= '0;
    end else if (clr) begin
      for (int f = 0; f < NUM_FEATURE_OUT; f++) acc[f] <= '0;
    end else if (en) begin
      for (int f = 0; f < NUM_FEATURE_OUT; f++) acc[f] <= acc[f] + prod[f];
    end
  end

  // Arithmetic shift drops the alpha fraction rounding toward -inf, then clamp.
  always_comb begin
    feat = '0;
    for (int f = 0; f < NUM_FEATURE_OUT; f++) begin
      shifted[f] = acc[f] >>> ALPHA_FRAC;
      if (shifted[f] > SAT_MAX)      shifted[f] = SAT_MAX;
      else if (shifted[f] < SAT_MIN) shifted[f] = SAT_MIN;
      feat[f*AGG_DATA_WIDTH +: AGG_DATA_WIDTH] = shifted[f][AGG_DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/gat_aggregator.sv
// Purpose: per destination node, reads N neighbour WH rows and emits the alpha-weighted sum.
// Latency: job sampled at E0 -> reads from E0+1 -> feat_valid_o at E0+N+2 (ready high).
// Backpressure: feat_o held while feat_ready_i=0; one pending job queued, further jobs dropped (overflow_o).
// Ports: clk, rst_n, bus (gat_aggregator_if.slave: job input, WH read port, feature output, status).
module gat_aggregator
  import gat_aggregator_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  gat_aggregator_if.slave bus
);

  agg_state_t                                state;
  agg_job_t                                  active_job;
  agg_job_t                                  pend_job;
  agg_job_t                                  in_job;
  logic                                      pend_vld;
  logic [NODE_IDX_W-1:0]                     issue_idx;
  logic                                      rd_vld_q;
  logic [NODE_IDX_W-1:0]                     rd_idx_q;
  logic                                      feat_vld_q;
  logic [NUM_FEATURE_OUT*AGG_DATA_WIDTH-1:0] feat_q;
  logic [NUM_FEATURE_OUT*AGG_DATA_WIDTH-1:0] mac_feat;
  logic                                      overflow_q;
  logic                                      xfer;
  logic                                      last_issue;
  logic                                      direct_promote;

  assign in_job.alpha = bus.alpha_i;
  assign in_job.num   = clamp_nodes(bus.sm_num_of_nodes_i);
  assign in_job.base  = bus.wh_base_addr_i;

  assign xfer       = (state == AGG_OUT) & feat_vld_q & bus.feat_ready_i;
  assign last_issue = ({1'b0, issue_idx} == (active_job.num - NUM_NODE_WIDTH'(1)));
  // A job arriving on the transfer edge with nothing queued skips the pending
  // slot and becomes active on that same edge.
  assign direct_promote = xfer & ~pend_vld & bus.sm_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= AGG_IDLE;
      active_job <= '0;
      pend_job   <= '0;
      pend_vld   <= 1'b0;
      issue_idx  <= '0;
      feat_vld_q <= 1'b0;
      feat_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (bus.sm_ready_i && (state != AGG_IDLE) && !direct_promote) begin
        if (!pend_vld) begin
          pend_job <= in_job;
          pend_vld <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end

      case (state)
        AGG_IDLE: begin
          if (bus.sm_ready_i) begin
            active_job <= in_job;
            issue_idx  <= '0;
            state      <= start_state(in_job.num);
          end
        end
        AGG_RUN: begin
          issue_idx <= issue_idx + NODE_IDX_W'(1);
          if (last_issue) state <= AGG_DRAIN;
        end
        AGG_DRAIN: begin
          // last row lands this cycle and is accumulated on the way out
          state <= AGG_OUT;
        end
        AGG_OUT: begin
          // first OUT cycle captures the fully accumulated, saturated vector
          if (!feat_vld_q) begin
            feat_q     <= mac_feat;
            feat_vld_q <= 1'b1;
          end else if (bus.feat_ready_i) begin
            feat_vld_q <= 1'b0;
            issue_idx  <= '0;
            if (pend_vld) begin
              active_job <= pend_job;
              pend_vld   <= 1'b0;
              state      <= start_state(pend_job.num);
            end else if (bus.sm_ready_i) begin
              active_job <= in_job;
              state      <= start_state(in_job.num);
            end else begin
              state <= AGG_IDLE;
            end
          end
        end
        default: state <= AGG_IDLE;
      endcase
    end
  end

  // Read-data tag pipe: marks the cycle a requested row is on wh_rd_data_i and
  // remembers which neighbour (alpha index) it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      rd_vld_q <= (state == AGG_RUN);
      rd_idx_q <= issue_idx;
    end
  end

  gat_agg_mac u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (xfer),
    .en     (rd_vld_q),
    .wh_row (bus.wh_rd_data_i),
    .alpha  (active_job.alpha[rd_idx_q]),
    .feat   (mac_feat)
  );

  assign bus.wh_rd_en_o   = (state == AGG_RUN);
  assign bus.wh_rd_addr_o = active_job.base + WH_ADDR_W'(issue_idx);  // wraps mod 2^WH_ADDR_W
  assign bus.feat_valid_o = feat_vld_q;
  assign bus.feat_o       = feat_q;
  assign bus.agg_busy_o   = (state != AGG_IDLE);
  assign bus.overflow_o   = overflow_q;

endmodule

// File: tb/tb_gat_aggregator.sv
module tb_gat_aggregator;
  import gat_aggregator_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gat_aggregator_if bus ();

  gat_aggregator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic signed [15:0] mem [4096][16];
  int unsigned        alpha_tab [3][MAX_NODES];

  // WH buffer: row returned one cycle after the read enable
  always @(posedge clk) begin
    if (bus.wh_rd_en_o)
      for (int f = 0; f < 16; f++)
        bus.wh_rd_data_i[f*16 +: 16] <= mem[bus.wh_rd_addr_o][f];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          n;
    int          base;
    int unsigned a0, a1, a2;
    int          w0, w1, w2;
    longint      exp0;
    int          lat;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Reference: sum over neighbours of WH[f] * alpha, floor-divided by 2^16, clamped to int32.
  function automatic longint ref_feat(int slot, int f, int n, int base);
    longint s = 0;
    int nc = (n > MAX_NODES) ? MAX_NODES : n;
    for (int k = 0; k < nc; k++)
      s += longint'(mem[(base + k) % 4096][f]) * longint'(alpha_tab[slot][k]);
    s = s >>> 16;
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    return s;
  endfunction

  function automatic longint dut_feat(int f);
    return longint'($signed(bus.feat_o[f*32 +: 32]));
  endfunction

  task automatic drive_job(input int slot, input int n, input int base);
    bus.sm_ready_i        = 1'b1;
    bus.sm_num_of_nodes_i = 9'(n);
    bus.wh_base_addr_i    = 12'(base);
    for (int k = 0; k < MAX_NODES; k++) bus.alpha_i[k*32 +: 32] = alpha_tab[slot][k];
  endtask

  task automatic check_vec(input string tag, input int slot, input int n, input int base);
    for (int f = 0; f < 16; f++)
      check($sformatf("%s_feat%0d", tag, f), dut_feat(f), ref_feat(slot, f, n, base));
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int lat = -1;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (bus.feat_valid_o) begin lat = c; break; end
    end
    check({tag, "_valid_seen"}, longint'(lat >= 0), 1);
  endtask

  // One job with ready held high: checks read addresses, latency, vector, transfer.
  task automatic run_job(input string tag, input int slot, input int n, input int base,
                         input int exp_lat, output longint f0);
    int nc = (n > MAX_NODES) ? MAX_NODES : n;
    int lat = -1;
    int rd = 0;
    f0 = 0;
    bus.feat_ready_i = 1'b1;
    @(negedge clk);
    drive_job(slot, n, base);
    for (int c = 0; c < nc + 40 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (c == 0) bus.sm_ready_i = 1'b0;
      if (bus.wh_rd_en_o) begin
        check($sformatf("%s_addr%0d", tag, rd), longint'(bus.wh_rd_addr_o),
              longint'((base + rd) % 4096));
        rd++;
      end
      if (bus.feat_valid_o) lat = c;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_rd_count"}, rd, nc);
    if (lat >= 0) begin
      check_vec(tag, slot, n, base);
      f0 = dut_feat(0);
      @(posedge clk); #1;
      check({tag, "_after_xfer_valid"}, longint'(bus.feat_valid_o), 0);
      check({tag, "_after_xfer_busy"}, longint'(bus.agg_busy_o), 0);
    end
  endtask

  vec_t   vecs [6];
  longint f0;
  int     extra;

  initial begin
    rst_n                 = 1'b0;
    bus.sm_ready_i        = 1'b0;
    bus.alpha_i           = '0;
    bus.sm_num_of_nodes_i = '0;
    bus.wh_base_addr_i    = '0;
    bus.feat_ready_i      = 1'b1;
    for (int a = 0; a < 4096; a++)
      for (int f = 0; f < 16; f++) mem[a][f] = 16'($urandom_range(0, 65535));

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en",    longint'(bus.wh_rd_en_o), 0);
    check("rst_rd_addr",  longint'(bus.wh_rd_addr_o), 0);
    check("rst_valid",    longint'(bus.feat_valid_o), 0);
    check("rst_feat",     longint'(bus.feat_o == '0), 1);
    check("rst_busy",     longint'(bus.agg_busy_o), 0);
    check("rst_overflow", longint'(bus.overflow_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- directed table ----------------
    vecs[0] = '{2, 10,    32'h8000,      32'h8000,      32'h0,     100,    -40,    0, 30, 4};
    vecs[1] = '{1, 100,   32'h4000,      32'h0,         32'h0,     -3,     0,      0, -1, 3};
    vecs[2] = '{0, 200,   32'h0,         32'h0,         32'h0,     0,      0,      0, 0,  2};
    vecs[3] = '{2, 300,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,     32767,  32767,  0,
                64'sd2147483647, 4};
    vecs[4] = '{2, 400,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,     -32768, -32768, 0,
                -64'sd2147483648, 4};
    vecs[5] = '{3, 12'hFFF, 32'h10000,   32'h10000,     32'h10000, 1,      2,      3, 6,  5};
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < MAX_NODES; k++) alpha_tab[0][k] = 0;
      alpha_tab[0][0] = vecs[i].a0;
      alpha_tab[0][1] = vecs[i].a1;
      alpha_tab[0][2] = vecs[i].a2;
      mem[(vecs[i].base + 0) % 4096][0] = 16'(vecs[i].w0);
      mem[(vecs[i].base + 1) % 4096][0] = 16'(vecs[i].w1);
      mem[(vecs[i].base + 2) % 4096][0] = 16'(vecs[i].w2);
      run_job($sformatf("tab%0d", i), 0, vecs[i].n, vecs[i].base, vecs[i].lat, f0);
      check($sformatf("tab%0d_feat0_expected", i), f0, vecs[i].exp0);
    end
    check("tab_no_overflow", longint'(bus.overflow_o), 0);

    // ---------------- backpressure, pending, overflow ----------------
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < MAX_NODES; k++) alpha_tab[s][k] = $urandom_range(0, 32'h1_FFFF);
    bus.feat_ready_i = 1'b0;
    @(negedge clk); drive_job(0, 3, 500);
    @(posedge clk); #1; bus.sm_ready_i = 1'b0;
    @(negedge clk); drive_job(1, 2, 600);
    @(posedge clk); #1; bus.sm_ready_i = 1'b0;
    check("bp_busy", longint'(bus.agg_busy_o), 1);
    check("bp_no_overflow_yet", longint'(bus.overflow_o), 0);
    @(negedge clk); drive_job(2, 1, 700);
    @(posedge clk); #1; bus.sm_ready_i = 1'b0;
    check("bp_overflow_set", longint'(bus.overflow_o), 1);
    wait_valid("bp_a", 40);
    check_vec("bp_a", 0, 3, 500);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_valid", c), longint'(bus.feat_valid_o), 1);
      check($sformatf("bp_hold%0d_f0", c),  dut_feat(0),  ref_feat(0, 0, 3, 500));
      check($sformatf("bp_hold%0d_f15", c), dut_feat(15), ref_feat(0, 15, 3, 500));
    end
    @(negedge clk); bus.feat_ready_i = 1'b1;
    @(posedge clk); #1;
    check("bp_b_start_rd_en", longint'(bus.wh_rd_en_o), 1);
    check("bp_b_start_addr",  longint'(bus.wh_rd_addr_o), 600);
    check("bp_b_start_valid", longint'(bus.feat_valid_o), 0);
    wait_valid("bp_b", 40);
    check_vec("bp_b", 1, 2, 600);
    extra = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (bus.feat_valid_o) extra++;
    end
    check("bp_only_two_vectors", extra, 0);
    check("bp_overflow_sticky", longint'(bus.overflow_o), 1);
    check("bp_idle_after", longint'(bus.agg_busy_o), 0);

    // ---------------- job arriving on the transfer edge ----------------
    @(negedge clk); drive_job(0, 2, 800);
    @(posedge clk); #1; bus.sm_ready_i = 1'b0;
    wait_valid("sc_d", 40);
    check_vec("sc_d", 0, 2, 800);
    @(negedge clk); drive_job(1, 3, 900);
    @(posedge clk); #1; bus.sm_ready_i = 1'b0;
    check("sc_e_rd_en", longint'(bus.wh_rd_en_o), 1);
    check("sc_e_addr",  longint'(bus.wh_rd_addr_o), 900);
    check("sc_e_busy",  longint'(bus.agg_busy_o), 1);
    wait_valid("sc_e", 40);
    check_vec("sc_e", 1, 3, 900);
    @(posedge clk); #1;
    check("sc_e_done", longint'(bus.agg_busy_o), 0);

    // ---------------- reset in the middle of RUN ----------------
    @(negedge clk); drive_job(0, 6, 1000);
    @(posedge clk); #1; bus.sm_ready_i = 1'b0;
    @(posedge clk); #1;
    check("mid_running", longint'(bus.wh_rd_en_o), 1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("mid_rst_rd_en",    longint'(bus.wh_rd_en_o), 0);
    check("mid_rst_addr",     longint'(bus.wh_rd_addr_o), 0);
    check("mid_rst_valid",    longint'(bus.feat_valid_o), 0);
    check("mid_rst_busy",     longint'(bus.agg_busy_o), 0);
    check("mid_rst_overflow", longint'(bus.overflow_o), 0);
    check("mid_rst_feat",     longint'(bus.feat_o == '0), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_job("post_rst", 1, 4, 1100, 6, f0);

    // ---------------- randomized jobs vs reference model ----------------
    for (int i = 0; i < 20; i++) begin
      int n    = $urandom_range(0, 180);
      int base = $urandom_range(0, 4095);
      int mode = $urandom_range(0, 2);
      for (int k = 0; k < MAX_NODES; k++)
        alpha_tab[2][k] = (mode == 0) ? $urandom() : $urandom_range(0, 32'h2_0000);
      run_job($sformatf("rnd%0d", i), 2, n, base, ((n > MAX_NODES) ? MAX_NODES : n) + 2, f0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
